// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the hazard/forwarding controller: forward selects and stall FSM states.
package hazard_forward_unit_pkg;
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_t;

    // Wide enough for LOAD_STALL_CYC up to 15.
    localparam int STALL_CNT_W = 4;
endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Forwarding select for one EX operand: MEM beats WB beats register file, with optional register-0 guard.
module fwd_select
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W         = 2,
    parameter int ZERO_REG_HARDWIRED = 0
) (
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    output fwd_sel_t              sel
);
    logic src_ok;

    // A matching source implies a matching destination, so guarding the source covers both.
    assign src_ok = !((ZERO_REG_HARDWIRED != 0) && (ex_rs == '0));

    always_comb begin
        sel = FWD_RF;
        if (src_ok && mem_reg_write && (mem_rd == ex_rs)) begin
            sel = FWD_MEM;
        end else if (src_ok && wb_reg_write && (wb_rd == ex_rs)) begin
            sel = FWD_WB;
        end
    end
endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller for the 5-stage pipe: operand forwarding, load-use stall FSM, flush control.
// Optional macro HAZARD_PERF_CNT_EN implements the stall/flush performance counters; otherwise they read 0.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W         = 2,
    parameter int LOAD_STALL_CYC     = 1,
    parameter int ZERO_REG_HARDWIRED = 0,
    parameter int CNT_W              = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    input  logic                  branch_taken,
    input  logic                  jump_id,
    input  logic                  mem_busy,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_write,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);
    fwd_sel_t               sel_a, sel_b;
    hz_state_t              state, state_d;
    logic [STALL_CNT_W-1:0] cnt, cnt_d;
    logic                   rs1_hit, rs2_hit, load_use, hz_bubble;

    fwd_select #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)) u_fwd_a (
        .ex_rs(ex_rs1), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .sel(sel_a)
    );
    fwd_select #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)) u_fwd_b (
        .ex_rs(ex_rs2), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .sel(sel_b)
    );

    assign forward_a = reset ? FWD_RF : sel_a;
    assign forward_b = reset ? FWD_RF : sel_b;

    assign rs1_hit  = id_use_rs1 && (ex_rd == id_rs1) && !((ZERO_REG_HARDWIRED != 0) && (id_rs1 == '0));
    assign rs2_hit  = id_use_rs2 && (ex_rd == id_rs2) && !((ZERO_REG_HARDWIRED != 0) && (id_rs2 == '0));
    assign load_use = ex_mem_read && ex_reg_write && (rs1_hit || rs2_hit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        hz_bubble   = 1'b0;
        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
        end else if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = ST_RUN;
            cnt_d       = '0;
        end else if (state == ST_STALL) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            hz_bubble   = 1'b1;
            if (cnt <= STALL_CNT_W'(1)) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt - 1'b1;
            end
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            hz_bubble   = 1'b1;
            if (LOAD_STALL_CYC > 1) begin
                state_d = ST_STALL;
                cnt_d   = STALL_CNT_W'(LOAD_STALL_CYC - 1);
            end
        end else if (jump_id) begin
            ifid_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (hz_bubble && !(&stall_count)) stall_count <= stall_count + 1'b1;
            if (ifid_flush && !(&flush_count)) flush_count <= flush_count + 1'b1;
        end
    end
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: a 3-bubble instance and a 1-bubble register-0-hardwired instance.
module tb_hazard_forward_unit;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
    logic       branch_taken, jump_id, mem_busy;

    logic [1:0]  fa, fb, fa_z, fb_z;
    logic        pcw, ifw, idw, fl, bb, pcw_z, ifw_z, idw_z, fl_z, bb_z;
    logic [15:0] sc, fc, sc_z, fc_z;

    int total = 0;
    int bad = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_ADDR_W(2), .LOAD_STALL_CYC(3), .ZERO_REG_HARDWIRED(0), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .branch_taken(branch_taken), .jump_id(jump_id), .mem_busy(mem_busy),
        .forward_a(fa), .forward_b(fb), .pc_write(pcw), .ifid_write(ifw), .idex_write(idw),
        .ifid_flush(fl), .idex_bubble(bb), .stall_count(sc), .flush_count(fc)
    );

    hazard_forward_unit #(.REG_ADDR_W(2), .LOAD_STALL_CYC(1), .ZERO_REG_HARDWIRED(1), .CNT_W(16)) dut_z (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .branch_taken(branch_taken), .jump_id(jump_id), .mem_busy(mem_busy),
        .forward_a(fa_z), .forward_b(fb_z), .pc_write(pcw_z), .ifid_write(ifw_z), .idex_write(idw_z),
        .ifid_flush(fl_z), .idex_bubble(bb_z), .stall_count(sc_z), .flush_count(fc_z)
    );

    task automatic clear_inputs();
        id_rs1 = 2'd0; id_rs2 = 2'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rs1 = 2'd0; ex_rs2 = 2'd0; ex_rd = 2'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_rd = 2'd0; mem_reg_write = 1'b0; wb_rd = 2'd0; wb_reg_write = 1'b0;
        branch_taken = 1'b0; jump_id = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 2'd1;
        id_rs2 = 2'd1; id_use_rs2 = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_reg_write = 1'b1; mem_rd = 2'd2; ex_rs1 = 2'd2; jump_id = 1'b1;
        step();
        total++; if (fa !== 2'd0) begin bad++; $display("FAIL rst_fwd_a got=%0d exp=0", fa); end
        total++; if ({pcw, ifw, idw, fl, bb} !== 5'b0) begin bad++; $display("FAIL rst_ctrl got=%b exp=00000", {pcw, ifw, idw, fl, bb}); end
        total++; if (sc !== 16'd0 || fc !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", sc, fc); end
        clear_inputs();
        reset = 1'b0;
        #1;
        total++; if ({pcw, ifw, idw, fl, bb} !== 5'b11100) begin bad++; $display("FAIL rst_release got=%b exp=11100", {pcw, ifw, idw, fl, bb}); end
    endtask

    task automatic test_forwarding();
        mem_reg_write = 1'b1; mem_rd = 2'd2; wb_reg_write = 1'b1; wb_rd = 2'd2; ex_rs1 = 2'd2; ex_rs2 = 2'd3;
        #1;
        total++; if (fa !== 2'd2) begin bad++; $display("FAIL fwd_mem_prio got=%0d exp=2", fa); end
        total++; if (fb !== 2'd0) begin bad++; $display("FAIL fwd_b_none got=%0d exp=0", fb); end
        mem_reg_write = 1'b0;
        #1;
        total++; if (fa !== 2'd1) begin bad++; $display("FAIL fwd_wb got=%0d exp=1", fa); end
        wb_rd = 2'd3; mem_reg_write = 1'b1; mem_rd = 2'd1;
        #1;
        total++; if (fb !== 2'd1 || fa !== 2'd0) begin bad++; $display("FAIL fwd_b_wb got=%0d/%0d exp=1/0", fb, fa); end
        mem_rd = 2'd3; wb_reg_write = 1'b0;
        #1;
        total++; if (fb !== 2'd2) begin bad++; $display("FAIL fwd_b_mem got=%0d exp=2", fb); end
        clear_inputs();
        mem_reg_write = 1'b1; mem_rd = 2'd0; ex_rs1 = 2'd0;
        #1;
        total++; if (fa !== 2'd2) begin bad++; $display("FAIL fwd_r0_plain got=%0d exp=2", fa); end
        total++; if (fa_z !== 2'd0) begin bad++; $display("FAIL fwd_r0_hardwired got=%0d exp=0", fa_z); end
        clear_inputs();
        #1;
    endtask

    task automatic test_load_use();
        set_load_use();
        #1;
        total++; if ({pcw, ifw, idw, bb} !== 4'b0011) begin bad++; $display("FAIL ld_c1 got=%b exp=0011", {pcw, ifw, idw, bb}); end
        total++; if (bb_z !== 1'b1) begin bad++; $display("FAIL ld_z_c1 got=%b exp=1", bb_z); end
        step();
        clear_inputs();
        #1;
        total++; if (bb_z !== 1'b0 || pcw_z !== 1'b1) begin bad++; $display("FAIL ld_z_c2 got=%b%b exp=01", bb_z, pcw_z); end
        for (int i = 2; i <= 3; i++) begin
            total++; if (pcw !== 1'b0 || bb !== 1'b1) begin bad++; $display("FAIL ld_c%0d got=%b%b exp=01", i, pcw, bb); end
            step();
        end
        total++; if (pcw !== 1'b1 || bb !== 1'b0) begin bad++; $display("FAIL ld_done got=%b%b exp=10", pcw, bb); end
        exp_stall += 3;
        total++; if (sc !== (PERF ? 16'(exp_stall) : 16'd0)) begin bad++; $display("FAIL ld_stall_count got=%0d exp=%0d", sc, PERF ? exp_stall : 0); end
    endtask

    task automatic test_zero_load();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 2'd0; id_rs1 = 2'd0; id_use_rs1 = 1'b1;
        #1;
        total++; if (bb_z !== 1'b0 || pcw_z !== 1'b1) begin bad++; $display("FAIL r0_load_z got=%b%b exp=01", bb_z, pcw_z); end
        total++; if (bb !== 1'b1) begin bad++; $display("FAIL r0_load_plain got=%b exp=1", bb); end
        step();
        clear_inputs();
        step();
        step();
        exp_stall += 3;
        total++; if (bb !== 1'b0) begin bad++; $display("FAIL r0_load_done got=%b exp=0", bb); end
    endtask

    task automatic test_branch_in_stall();
        set_load_use();
        step();
        clear_inputs();
        branch_taken = 1'b1;
        #1;
        total++; if ({pcw, fl, bb} !== 3'b111) begin bad++; $display("FAIL br_stall got=%b exp=111", {pcw, fl, bb}); end
        step();
        clear_inputs();
        #1;
        total++; if ({pcw, fl, bb} !== 3'b100) begin bad++; $display("FAIL br_after got=%b exp=100", {pcw, fl, bb}); end
        exp_stall += 1;
        exp_flush += 1;
        total++; if (fc !== (PERF ? 16'(exp_flush) : 16'd0)) begin bad++; $display("FAIL br_flush_count got=%0d exp=%0d", fc, PERF ? exp_flush : 0); end
    endtask

    task automatic test_mem_busy_stall();
        set_load_use();
        step();
        clear_inputs();
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if ({pcw, ifw, idw, fl, bb} !== 5'b0) begin bad++; $display("FAIL busy_c%0d got=%b exp=00000", i, {pcw, ifw, idw, fl, bb}); end
            step();
        end
        mem_busy = 1'b0;
        #1;
        for (int i = 2; i <= 3; i++) begin
            total++; if (pcw !== 1'b0 || bb !== 1'b1) begin bad++; $display("FAIL busy_resume%0d got=%b%b exp=01", i, pcw, bb); end
            step();
        end
        total++; if (pcw !== 1'b1 || bb !== 1'b0) begin bad++; $display("FAIL busy_done got=%b%b exp=10", pcw, bb); end
        exp_stall += 3;
    endtask

    task automatic test_jump();
        jump_id = 1'b1;
        #1;
        total++; if ({pcw, ifw, idw, fl, bb} !== 5'b11110) begin bad++; $display("FAIL jump got=%b exp=11110", {pcw, ifw, idw, fl, bb}); end
        step();
        clear_inputs();
        #1;
        exp_flush += 1;
        total++; if (sc !== (PERF ? 16'(exp_stall) : 16'd0)) begin bad++; $display("FAIL total_stall_count got=%0d exp=%0d", sc, PERF ? exp_stall : 0); end
        total++; if (fc !== (PERF ? 16'(exp_flush) : 16'd0)) begin bad++; $display("FAIL total_flush_count got=%0d exp=%0d", fc, PERF ? exp_flush : 0); end
    endtask

    task automatic test_reset_mid_stall();
        set_load_use();
        step();
        clear_inputs();
        mem_reg_write = 1'b1; mem_rd = 2'd1; ex_rs1 = 2'd1;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            total++; if ({pcw, ifw, idw, fl, bb} !== 5'b0 || fa !== 2'd0) begin bad++; $display("FAIL rst_mid_c%0d got=%b fa=%0d exp=00000 fa=0", i, {pcw, ifw, idw, fl, bb}, fa); end
            step();
        end
        clear_inputs();
        reset = 1'b0;
        #1;
        total++; if (pcw !== 1'b1 || bb !== 1'b0) begin bad++; $display("FAIL rst_mid_release got=%b%b exp=10", pcw, bb); end
        step();
        total++; if (pcw !== 1'b1 || sc !== 16'd0 || fc !== 16'd0) begin bad++; $display("FAIL rst_mid_after pcw=%b cnt=%0d/%0d exp=1 0/0", pcw, sc, fc); end
        total++; if (sc_z !== 16'd0 || fc_z !== 16'd0) begin bad++; $display("FAIL rst_mid_z_cnt got=%0d/%0d exp=0/0", sc_z, fc_z); end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_forwarding();
        test_load_use();
        test_zero_load();
        test_branch_in_stall();
        test_mem_busy_stall();
        test_jump();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
